pool_stream: RTL and testbench

- Parametrised, multi-channel streaming pooling stage that replaces the gated-clock max-pool used between conv layers.
- Consumes a raster-order pixel stream qualified by `in_valid` and produces one pooled value per channel per K×K window, with a valid strobe.
- Supports MAX or AVG mode, any frame size, and gaps in the input stream.
- Sits directly after a convolution block inside a layer wrapper, on the single system clock.

---
 rtl/pool_stream.sv | 135 +++++++++++++
 tb/tb_pool_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream.sv
// pool_stream: streaming K x K non-overlapping max/avg pooling over a raster-order pixel stream.
// Horizontal partials are kept per lane; vertical partials live in an NO-entry column buffer per lane.
module pool_stream #(
  parameter int PP   = 8,
  parameter int DIM  = 10,
  parameter int K    = 2,
  parameter int CH   = 1,
  parameter int MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [CH*(PP+1)-1:0]       pxl_in,
  output logic [CH*(PP+1)-1:0]       pool_out,
  output logic                       out_valid,
  output logic [$clog2(DIM/K):0]     out_col,
  output logic                       frame_done
);

  localparam int W      = PP + 1;
  localparam int NO     = DIM / K;
  localparam int LK     = $clog2(K);
  localparam int SH     = 2 * LK;
  localparam int AW     = W + SH;
  localparam int CW     = $clog2(DIM + 1);
  localparam int IW     = (NO > 1) ? $clog2(NO) : 1;
  localparam int OCW    = $clog2(DIM / K) + 1;
  localparam int REGION = NO * K;

  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_row;
  logic signed [AW-1:0] r_hacc [CH];
  logic signed [AW-1:0] r_vacc [CH][NO];
  logic [CH*W-1:0]      r_pool_out;
  logic                 r_out_valid;
  logic [OCW-1:0]       r_out_col;
  logic                 r_frame_done;

  logic [LK-1:0]        w_col_ph;
  logic [LK-1:0]        w_row_ph;
  logic [CW-1:0]        w_wcol;
  logic [IW-1:0]        w_vidx;
  logic                 w_in_region;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_emit;
  logic                 w_frame_last;
  logic signed [AW-1:0] w_hres [CH];
  logic signed [AW-1:0] w_vres [CH];

  // Max keeps the larger signed value; avg accumulates a sum at the widened width.
  function automatic logic signed [AW-1:0] f_comb(input logic signed [AW-1:0] a,
                                                  input logic signed [AW-1:0] b);
    if (MODE == 0) begin
      if (a > b) f_comb = a;
      else       f_comb = b;
    end else begin
      f_comb = a + b;
    end
  endfunction

  function automatic logic [W-1:0] f_final(input logic signed [AW-1:0] v);
    if (MODE == 0) f_final = W'(v);
    else           f_final = W'(v >>> SH);
  endfunction

  assign w_col_ph     = r_col[LK-1:0];
  assign w_row_ph     = r_row[LK-1:0];
  assign w_wcol       = r_col >> LK;
  assign w_in_region  = (r_col < CW'(REGION)) && (r_row < CW'(REGION));
  // Clamp keeps the buffer index legal for pixels outside the pooled region.
  assign w_vidx       = w_in_region ? IW'(w_wcol) : {IW{1'b0}};
  assign w_col_last   = (w_col_ph == LK'(K - 1));
  assign w_row_last   = (w_row_ph == LK'(K - 1));
  assign w_emit       = in_valid && w_in_region && w_col_last && w_row_last;
  assign w_frame_last = (r_col == CW'(DIM - 1)) && (r_row == CW'(DIM - 1));

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_hres[c] = {AW{1'b0}};
      w_vres[c] = {AW{1'b0}};
    end
    for (int c = 0; c < CH; c++) begin
      if (w_col_ph == {LK{1'b0}}) w_hres[c] = AW'($signed(pxl_in[c*W +: W]));
      else w_hres[c] = f_comb(r_hacc[c], AW'($signed(pxl_in[c*W +: W])));
      if (w_row_ph == {LK{1'b0}}) w_vres[c] = w_hres[c];
      else w_vres[c] = f_comb(r_vacc[c][w_vidx], w_hres[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col        <= {CW{1'b0}};
      r_row        <= {CW{1'b0}};
      r_pool_out   <= {(CH*W){1'b0}};
      r_out_valid  <= 1'b0;
      r_out_col    <= {OCW{1'b0}};
      r_frame_done <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        r_hacc[c] <= {AW{1'b0}};
        for (int j = 0; j < NO; j++) r_vacc[c][j] <= {AW{1'b0}};
      end
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        if (r_col == CW'(DIM - 1)) begin
          r_col <= {CW{1'b0}};
          if (r_row == CW'(DIM - 1)) r_row <= {CW{1'b0}};
          else                       r_row <= r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (w_in_region) begin
          for (int c = 0; c < CH; c++) begin
            r_hacc[c] <= w_hres[c];
            if (w_col_last) r_vacc[c][w_vidx] <= w_vres[c];
          end
        end
        if (w_emit) begin
          r_out_valid <= 1'b1;
          r_out_col   <= OCW'(w_wcol);
          for (int c = 0; c < CH; c++) r_pool_out[c*W +: W] <= f_final(w_vres[c]);
        end
        r_frame_done <= w_frame_last;
      end
    end
  end

  assign pool_out   = r_pool_out;
  assign out_valid  = r_out_valid;
  assign out_col    = r_out_col;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: a table of 2x2 windows drives a 2-lane max DUT and a 2-lane avg DUT (DIM=4);
// a DIM=5 max DUT covers the unpooled edge. Expected results are queued at drive time and checked on strobe.
module tb_pool_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        ab_valid;
  logic [17:0] ab_pxl;
  logic [17:0] a_out, b_out;
  logic        a_ov, b_ov, a_fd, b_fd;
  logic [1:0]  a_col, b_col;
  logic        c_valid;
  logic [8:0]  c_pxl;
  logic [8:0]  c_out;
  logic        c_ov, c_fd;
  logic [1:0]  c_col;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int v0; int v1; int col; int cyc; } exp_t;
  exp_t qa[$], qb[$], qc[$];
  int   fa[$], fb[$], fc[$];

  typedef struct packed {
    logic [3:0][8:0] l0;
    logic [3:0][8:0] l1;
    logic [8:0]      mx0, mx1, av0, av1;
  } win_t;
  win_t tbl[8];

  int c_idx[4] = '{6, 8, 16, 18};
  int c_val[4] = '{6, 8, 16, 18};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_stream #(.PP(8), .DIM(4), .K(2), .CH(2), .MODE(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(ab_valid), .pxl_in(ab_pxl),
    .pool_out(a_out), .out_valid(a_ov), .out_col(a_col), .frame_done(a_fd));
  pool_stream #(.PP(8), .DIM(4), .K(2), .CH(2), .MODE(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(ab_valid), .pxl_in(ab_pxl),
    .pool_out(b_out), .out_valid(b_ov), .out_col(b_col), .frame_done(b_fd));
  pool_stream #(.PP(8), .DIM(5), .K(2), .CH(1), .MODE(0)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_valid), .pxl_in(c_pxl),
    .pool_out(c_out), .out_valid(c_ov), .out_col(c_col), .frame_done(c_fd));

  // Window pixel order: (r0,c0), (r0,c1), (r1,c0), (r1,c1); then max/avg per lane.
  function automatic win_t mk(int a0, int a1, int a2, int a3, int b0, int b1, int b2, int b3,
                              int m0, int m1, int v0, int v1);
    win_t w;
    w.l0[0] = 9'(a0); w.l0[1] = 9'(a1); w.l0[2] = 9'(a2); w.l0[3] = 9'(a3);
    w.l1[0] = 9'(b0); w.l1[1] = 9'(b1); w.l1[2] = 9'(b2); w.l1[3] = 9'(b3);
    w.mx0 = 9'(m0); w.mx1 = 9'(m1); w.av0 = 9'(v0); w.av1 = 9'(v1);
    return w;
  endfunction

  task automatic check(string nm, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d", nm, act, expv);
    end
  endtask

  task automatic spurious(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual strobe 1 required 0 (nothing expected)", nm);
  endtask

  task automatic check_ev(string who, int nl, exp_t e, logic [17:0] pv, logic [1:0] col);
    check({who, " lane0"}, int'($signed(pv[8:0])), e.v0);
    if (nl > 1) check({who, " lane1"}, int'($signed(pv[17:9])), e.v1);
    check({who, " out_col"}, int'(col), e.col);
    check({who, " latency cycle"}, cyc, e.cyc);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (a_ov) begin
        if (qa.size() == 0) spurious("A out_valid");
        else check_ev("A", 2, qa.pop_front(), a_out, a_col);
      end
      if (b_ov) begin
        if (qb.size() == 0) spurious("B out_valid");
        else check_ev("B", 2, qb.pop_front(), b_out, b_col);
      end
      if (c_ov) begin
        if (qc.size() == 0) spurious("C out_valid");
        else check_ev("C", 1, qc.pop_front(), {9'd0, c_out}, c_col);
      end
      if (a_fd) begin
        if (fa.size() == 0) spurious("A frame_done");
        else check("A frame_done cycle", cyc, fa.pop_front());
      end
      if (b_fd) begin
        if (fb.size() == 0) spurious("B frame_done");
        else check("B frame_done cycle", cyc, fb.pop_front());
      end
      if (c_fd) begin
        if (fc.size() == 0) spurious("C frame_done");
        else check("C frame_done cycle", cyc, fc.pop_front());
      end
    end
  endtask

  task automatic chk_idle(string tag);
    check({tag, " A out_valid"}, int'(a_ov), 0);
    check({tag, " A pool_out"}, int'(a_out), 0);
    check({tag, " A out_col"}, int'(a_col), 0);
    check({tag, " A frame_done"}, int'(a_fd), 0);
    check({tag, " B pool_out"}, int'(b_out), 0);
    check({tag, " C out_valid"}, int'(c_ov), 0);
    check({tag, " C pool_out"}, int'(c_out), 0);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      ab_valid = 1'b0;
      c_valid  = 1'b0;
    end
  endtask

  // Drives npix pixels of table frame f to DUTs A/B; gap is the idle-cycle percentage.
  task automatic send_ab(int f, int gap, int npix);
    for (int n = 0; n < npix; n++) begin
      int r, c, w, e;
      exp_t x;
      r = n / 4; c = n % 4;
      w = f * 4 + (r / 2) * 2 + c / 2;
      e = (r % 2) * 2 + c % 2;
      while ($urandom_range(99) < gap) begin
        @(posedge clk); #1;
        ab_valid = 1'b0;
        ab_pxl   = 18'($urandom);
      end
      @(posedge clk); #1;
      ab_valid = 1'b1;
      ab_pxl   = {tbl[w].l1[e], tbl[w].l0[e]};
      if (e == 3) begin
        x.col = c / 2; x.cyc = cyc + 1;
        x.v0 = int'($signed(tbl[w].mx0)); x.v1 = int'($signed(tbl[w].mx1)); qa.push_back(x);
        x.v0 = int'($signed(tbl[w].av0)); x.v1 = int'($signed(tbl[w].av1)); qb.push_back(x);
      end
      if (n == 15) begin
        fa.push_back(cyc + 1);
        fb.push_back(cyc + 1);
      end
    end
  endtask

  task automatic send_c(int gap);
    for (int n = 0; n < 25; n++) begin
      exp_t x;
      while ($urandom_range(99) < gap) begin
        @(posedge clk); #1;
        c_valid = 1'b0;
        c_pxl   = 9'($urandom);
      end
      @(posedge clk); #1;
      c_valid = 1'b1;
      c_pxl   = 9'(n);
      for (int k = 0; k < 4; k++) begin
        if (n == c_idx[k]) begin
          x.v0 = c_val[k]; x.v1 = 0; x.col = k % 2; x.cyc = cyc + 1;
          qc.push_back(x);
        end
      end
      if (n == 24) fc.push_back(cyc + 1);
    end
  endtask

  initial begin
    reset = 1'b1; ab_valid = 1'b0; ab_pxl = 18'd0; c_valid = 1'b0; c_pxl = 9'd0;
    tbl[0] = mk(0, 1, 4, 5,       -1, -2, -3, -4,        5, -1, 2, -3);
    tbl[1] = mk(2, 3, 6, 7,       -100, -100, -3, -100,  7, -3, 4, -76);
    tbl[2] = mk(8, 9, 12, 13,     255, 255, 255, 255,    13, 255, 10, 255);
    tbl[3] = mk(10, 11, 14, 15,   -256, -256, -256, -256, 15, -256, 12, -256);
    tbl[4] = mk(-1, -2, -3, -4,   255, -256, 0, 1,       -1, 255, -3, 0);
    tbl[5] = mk(-100, -100, -3, -100, -1, 0, 0, 0,       -3, 0, -76, -1);
    tbl[6] = mk(3, 3, 3, 3,       0, 0, 0, -1,           3, 0, 3, -1);
    tbl[7] = mk(1, 2, 3, -7,      100, -50, 7, 200,      3, 200, -1, 64);
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // Continuous frames, back to back
    send_ab(0, 0, 16);
    send_ab(1, 0, 16);
    idle(3);
    // Same frames with random input gaps
    send_ab(0, 50, 16);
    send_ab(1, 50, 16);
    idle(3);
    // Abort mid-frame after pixel 6, then fresh frames with no gap between them
    send_ab(0, 0, 7);
    @(posedge clk); #1;
    reset = 1'b1; ab_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("mid-frame reset");
    send_ab(0, 0, 16);
    send_ab(0, 0, 16);
    send_ab(1, 0, 16);
    idle(3);
    // Non-multiple frame size: column 4 and row 4 are never pooled
    send_c(0);
    send_c(40);
    idle(6);

    check("A leftover results", qa.size(), 0);
    check("B leftover results", qb.size(), 0);
    check("C leftover results", qc.size(), 0);
    check("A leftover frame_done", fa.size(), 0);
    check("B leftover frame_done", fb.size(), 0);
    check("C leftover frame_done", fc.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
